lights_sequencer: RTL
=====================

# lights_sequencer

Controller that sequences the dynamic LED lights colour datapath. It turns a raw, bouncy push-button and an optional free-running auto-step timer into clean single-cycle `advance` pulses. Each pulse drives the `button` input of the LIGHTS block, which steps the 3-bit colour by one. It arbitrates between the manual and auto requesters, enforces a minimum spacing between steps, and holds one pending manual request.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised cycles required before a button level change is accepted (≥1).
- `MIN_GAP`, default 2: cycles after an `advance` during which no new `advance` may issue (≥0; 0 = back-to-back allowed).
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_raw` in 1: asynchronous raw push-button level.
- `auto_en` in 1: enables the auto-step timer.
- `auto_period` in 8: auto step interval minus one (fires every `auto_period+1` cycles).
- `advance` out 1: registered one-cycle step pulse, connects to LIGHTS `button`.
- `pending` out 1: a manual request is waiting out the gap.
- `holdoff` out 1: FSM is in HOLD.

## Operation
- Reset values: `advance`=0, `pending`=0, `holdoff`=0, synchroniser flops=0, debounced level=0, debounce and gap counters=0, auto timer=0, FSM=IDLE.
- Input path: 2-flop synchroniser on `btn_raw`. The debounced level toggles once the synchronised level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any mismatch-free cycle clears the counter. A rising edge of the debounced level raises a manual request (falling edges ignored).
- Auto timer: counts only when `auto_en`=1. It is cleared when `auto_en`=0 and on every issued `advance`. At `timer==auto_period` it raises an auto request and wraps to 0.
- FSM states: IDLE, HOLD.
  - IDLE:
    - A manual request (new or pending) issues `advance`.
    - Otherwise an auto request issues `advance`.
    - After issuing: go to HOLD if `MIN_GAP`>0, else stay in IDLE.
  - HOLD: the gap counter counts `MIN_GAP` cycles, then the FSM returns to IDLE.
- Manual request in HOLD: set `pending` (one-deep; further manual requests while pending are dropped). `pending` clears in the cycle its `advance` issues.
- Auto request in HOLD: dropped; the timer continues.
- Simultaneous manual and auto request in IDLE: manual wins; the auto request is dropped and the timer clears.
- `auto_period` change mid-count takes effect on the next compare. If the timer is already above the new value, it runs to 255 and wraps.
- `rst` mid-operation: all state returns to reset values on the next edge. Any pending request and any in-flight debounce are discarded.

## Timing
- `btn_raw` first sampled high at edge N and held: debounced level rises after edge N+1+`DEBOUNCE_CYCLES`, and `advance` is high for exactly the cycle after edge N+2+`DEBOUNCE_CYCLES`. With defaults, that is the cycle after edge N+6.
- Auto: with `auto_en` high from edge M and no contention, the first `advance` follows edge M+`auto_period`+1. Subsequent pulses follow every `auto_period`+1 edges, provided `auto_period`+1 > `MIN_GAP`.
- After an `advance` at cycle T, the next possible `advance` is at T+`MIN_GAP`+1. A pending manual request issues exactly then.
- `advance` is never high for two consecutive cycles when `MIN_GAP`>0.

## Configuration
- `LIGHTS_SEQ_AUTO_EN`:
  - Defined: auto-step timer and arbitration are compiled in, as above.
  - Undefined: no timer logic; `auto_en` and `auto_period` remain as ports but are ignored, and only manual requests produce `advance`. Manual behaviour and timing are identical in both builds.

## Structure
- Shared package `lights_pkg`:
  - FSM state enum (IDLE, HOLD).
  - Default constants for `DEBOUNCE_CYCLES`, `MIN_GAP` and the 8-bit period width.
  - 3-bit colour encoding constants used by LIGHTS.
- Sub-module `lights_debounce`: synchroniser, debounce counter and rising-edge detector. It outputs a one-cycle `press` pulse. The top level holds the timer, FSM, gap counter and pending flag.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `btn_raw`=1 and `auto_en`=1 → `advance`, `pending` and `holdoff` are all 0 throughout and the cycle after release.
- Bounce: `btn_raw` toggles every cycle for 10 cycles, then stays low → no `advance`. Then `btn_raw` high from edge N → a single `advance` in the cycle after edge N+6 and none after.
- Auto: `auto_en`=1, `auto_period`=4 → `advance` every 5 cycles. `auto_en`=0 → pulses stop within one cycle, and the timer restarts from 0 on re-enable.
- Contention: press timed so the manual request and the auto compare land in the same IDLE cycle → exactly one `advance`. The next auto pulse comes `auto_period`+1 cycles later.
- Gap/pending: `MIN_GAP`=3; a second press accepted 1 cycle after an `advance` → `pending`=1, then `advance` at T+4 and `pending` clears. A third press during the same HOLD is dropped.
- Macro off: build without `LIGHTS_SEQ_AUTO_EN`, `auto_en`=1, `auto_period`=0 → no `advance` for 50 cycles without a press. The manual press latency matches the Bounce test.

Source files
------------

// File: rtl/lights_pkg.sv
// rtl/lights_pkg.sv - shared types and defaults for the LED lights sequencer
package lights_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int MIN_GAP_DEF         = 2;
    localparam int PERIOD_W            = 8;

    // Colour codes stepped through by the LIGHTS block on each advance.
    typedef logic [2:0] colour_t;
    localparam colour_t COLOUR_OFF     = 3'd0;
    localparam colour_t COLOUR_RED     = 3'd1;
    localparam colour_t COLOUR_GREEN   = 3'd2;
    localparam colour_t COLOUR_YELLOW  = 3'd3;
    localparam colour_t COLOUR_BLUE    = 3'd4;
    localparam colour_t COLOUR_MAGENTA = 3'd5;
    localparam colour_t COLOUR_CYAN    = 3'd6;
    localparam colour_t COLOUR_WHITE   = 3'd7;

endpackage

// File: rtl/lights_debounce.sv
// rtl/lights_debounce.sv - button synchroniser, debouncer and press pulse generator
module lights_debounce
    import lights_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_q <= level;
            // Any cycle that agrees with the accepted level restarts the count.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/lights_sequencer.sv
// rtl/lights_sequencer.sv - arbitrates manual and auto steps into spaced advance pulses
// Define LIGHTS_SEQ_AUTO_EN to compile in the auto-step timer; otherwise only presses step.
module lights_sequencer
    import lights_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int MIN_GAP         = MIN_GAP_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_raw,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] auto_period,
    output logic                advance,
    output logic                pending,
    output logic                holdoff
);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    seq_state_t    state;
    seq_state_t    state_nx;
    logic [GW-1:0] gap_cnt;
    logic          press;
    logic          auto_req;
    logic          issue;
    logic          gap_done;

    lights_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .press  (press)
    );

`ifdef LIGHTS_SEQ_AUTO_EN
    logic [PERIOD_W-1:0] timer;

    // Equality compare: lowering the period below the count lets the timer run to wrap.
    assign auto_req = auto_en && (timer == auto_period);

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (issue || !auto_en || auto_req) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = auto_en ^ (^auto_period);
    assign auto_req    = 1'b0;
`endif

    assign gap_done = (gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Manual (fresh press or held-over) takes priority; a losing auto request is simply dropped.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE: begin
                if (press || pending || auto_req) begin
                    issue = 1'b1;
                    if (MIN_GAP > 0) begin
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (gap_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        holdoff = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            advance <= 1'b0;
            pending <= 1'b0;
            gap_cnt <= '0;
        end else begin
            advance <= issue;
            if (issue) begin
                pending <= 1'b0;
            end else if (press && (state == HOLD)) begin
                pending <= 1'b1;
            end
            if ((state == HOLD) && !gap_done) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule
